demux_1_2_sched: RTL and testbench

Packet-level scheduler for the 1:2 demultiplexer path. It accepts a valid/ready beat stream and latches the destination (`sel`) on the first beat of each packet. It holds that route until the packet's last beat is accepted, then delivers the beats through one registered stage per output channel. Each output has its own backpressure. The block also keeps a count of delivered packets per channel, and sits between the upstream stream source and the two downstream consumers.

---
 rtl/demux_1_2_sched.sv | 103 ++++++++++
 tb/tb_demux_1_2_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/demux_1_2_sched.sv
// rtl/demux_1_2_sched.sv - packet-level 1:2 demux scheduler with registered outputs
// Route is latched on the first beat and held until the last beat is accepted.
module demux_1_2_sched #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             din_last,
   input  logic             sel,
   output logic             din_ready,
   output logic [WIDTH-1:0] out1,
   output logic             out1_valid,
   output logic             out1_last,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2,
   output logic             out2_valid,
   output logic             out2_last,
   input  logic             out2_ready,
   output logic [CNT_W-1:0] pkt_cnt1,
   output logic [CNT_W-1:0] pkt_cnt2,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, PORT1, PORT2} state_t;

   state_t           r_state;
   logic             r_v1, r_l1, r_v2, r_l2;
   logic [WIDTH-1:0] r_d1, r_d2;
   logic [CNT_W-1:0] r_cnt1, r_cnt2;

   logic w_target, w_free1, w_free2, w_accept, w_load1, w_load2;

   // A register is free if empty or draining in this same cycle.
   assign w_target  = (r_state == IDLE) ? sel : (r_state == PORT2);
   assign w_free1   = !r_v1 || out1_ready;
   assign w_free2   = !r_v2 || out2_ready;
   assign din_ready = w_target ? w_free2 : w_free1;
   assign w_accept  = din_valid && din_ready;
   assign w_load1   = w_accept && !w_target;
   assign w_load2   = w_accept && w_target;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:          if (w_accept && !din_last) r_state <= sel ? PORT2 : PORT1;
            PORT1, PORT2:  if (w_accept && din_last)  r_state <= IDLE;
            default:       r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_l1   <= 1'b0;
         r_d1   <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_load1) begin
            r_v1 <= 1'b1;
            r_l1 <= din_last;
            r_d1 <= din;
         end else if (r_v1 && out1_ready) begin
            r_v1 <= 1'b0;
         end
         if (r_v1 && out1_ready && r_l1) r_cnt1 <= r_cnt1 + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2   <= 1'b0;
         r_l2   <= 1'b0;
         r_d2   <= '0;
         r_cnt2 <= '0;
      end else begin
         if (w_load2) begin
            r_v2 <= 1'b1;
            r_l2 <= din_last;
            r_d2 <= din;
         end else if (r_v2 && out2_ready) begin
            r_v2 <= 1'b0;
         end
         if (r_v2 && out2_ready && r_l2) r_cnt2 <= r_cnt2 + 1'b1;
      end
   end

   assign out1       = r_d1;
   assign out1_valid = r_v1;
   assign out1_last  = r_l1;
   assign out2       = r_d2;
   assign out2_valid = r_v2;
   assign out2_last  = r_l2;
   assign pkt_cnt1   = r_cnt1;
   assign pkt_cnt2   = r_cnt2;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_demux_1_2_sched.sv
// tb/tb_demux_1_2_sched.sv - vector table plus beat scoreboard for demux_1_2_sched
module tb_demux_1_2_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic       din_valid, din_last, sel, din_ready;
   logic [7:0] out1, out2;
   logic       out1_valid, out1_last, out1_ready;
   logic       out2_valid, out2_last, out2_ready;
   logic [1:0] pkt_cnt1, pkt_cnt2;
   logic       busy;

   demux_1_2_sched #(.WIDTH(8), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_last(din_last),
      .sel(sel), .din_ready(din_ready),
      .out1(out1), .out1_valid(out1_valid), .out1_last(out1_last), .out1_ready(out1_ready),
      .out2(out2), .out2_valid(out2_valid), .out2_last(out2_last), .out2_ready(out2_ready),
      .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       v, s, l, r1, r2, exp_rdy, exp_busy;
   } vec_t;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      chk_cnt++;
      $display("FAIL %s: got unexpected output beat expected none", name);
   endtask

   task automatic step(input vec_t v);
      @(posedge clk);
      #1;
      din = v.d; din_valid = v.v; sel = v.s; din_last = v.l;
      out1_ready = v.r1; out2_ready = v.r2;
      @(negedge clk);
   endtask

   // Scoreboard: expected beats queued per channel at input accept time.
   logic [8:0] q1[$], q2[$];
   logic [8:0] e;
   bit         in_pkt, route, ch;
   bit         hold1, hold2, pend1, pend2;
   logic [8:0] h1, h2;
   logic [1:0] exp_cnt1, exp_cnt2;

   always @(negedge clk) begin
      if (!rst_n) begin
         q1.delete(); q2.delete();
         in_pkt = 0; hold1 = 0; hold2 = 0; pend1 = 0; pend2 = 0;
         exp_cnt1 = 0; exp_cnt2 = 0;
      end else begin
         if (pend1) check("pkt_cnt1", 32'(pkt_cnt1), 32'(exp_cnt1));
         if (pend2) check("pkt_cnt2", 32'(pkt_cnt2), 32'(exp_cnt2));
         pend1 = 0; pend2 = 0;
         if (hold1) check("out1_hold", 32'({out1_valid, out1_last, out1}), 32'({1'b1, h1}));
         if (hold2) check("out2_hold", 32'({out2_valid, out2_last, out2}), 32'({1'b1, h2}));
         if (out1_valid && out1_ready) begin
            if (q1.size() == 0) fail("out1_extra");
            else begin
               e = q1.pop_front();
               check("out1_beat", 32'({out1_last, out1}), 32'(e));
               if (out1_last) begin exp_cnt1 = exp_cnt1 + 2'd1; pend1 = 1; end
            end
         end
         if (out2_valid && out2_ready) begin
            if (q2.size() == 0) fail("out2_extra");
            else begin
               e = q2.pop_front();
               check("out2_beat", 32'({out2_last, out2}), 32'(e));
               if (out2_last) begin exp_cnt2 = exp_cnt2 + 2'd1; pend2 = 1; end
            end
         end
         hold1 = out1_valid && !out1_ready; h1 = {out1_last, out1};
         hold2 = out2_valid && !out2_ready; h2 = {out2_last, out2};
         if (din_valid && din_ready) begin
            if (!in_pkt) route = sel;
            ch = route;
            if (ch) q2.push_back({din_last, din});
            else    q1.push_back({din_last, din});
            in_pkt = !din_last;
         end
      end
   end

   vec_t vecs[$];
   vec_t idle;
   int   wrap_exp[5] = '{1, 2, 3, 0, 1};

   initial begin
      idle = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      //          d      v  s  l  r1 r2 rdy busy
      vecs.push_back('{8'hA5, 1, 0, 1, 1, 1, 1, 0});
      vecs.push_back('{8'h00, 0, 0, 0, 1, 1, 1, 0});
      vecs.push_back('{8'h11, 1, 1, 0, 1, 1, 1, 0});
      vecs.push_back('{8'h22, 1, 0, 0, 1, 1, 1, 1});
      vecs.push_back('{8'h33, 1, 1, 0, 1, 1, 1, 1});
      vecs.push_back('{8'h44, 1, 0, 1, 1, 1, 1, 1});
      vecs.push_back('{8'h00, 0, 0, 0, 1, 1, 1, 0});
      vecs.push_back('{8'h61, 1, 0, 0, 0, 1, 1, 0});
      vecs.push_back('{8'h62, 1, 0, 0, 0, 1, 0, 1});
      vecs.push_back('{8'h62, 1, 0, 0, 0, 1, 0, 1});
      vecs.push_back('{8'h62, 1, 0, 0, 0, 1, 0, 1});
      vecs.push_back('{8'h62, 1, 0, 0, 1, 1, 1, 1});
      vecs.push_back('{8'h63, 1, 0, 1, 1, 1, 1, 1});
      vecs.push_back('{8'h00, 0, 0, 0, 1, 1, 1, 0});
      vecs.push_back('{8'h71, 1, 0, 1, 0, 1, 1, 0});
      vecs.push_back('{8'h5A, 1, 1, 1, 0, 1, 1, 0});
      vecs.push_back('{8'h00, 0, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{8'h00, 0, 0, 0, 1, 1, 1, 0});
      vecs.push_back('{8'h00, 0, 0, 0, 1, 1, 1, 0});

      rst_n = 0; din = 0; din_valid = 0; din_last = 0; sel = 0;
      out1_ready = 1; out2_ready = 1;
      #2;
      check("rst_out", 32'({out1_valid, out1_last, out1, out2_valid, out2_last, out2}), 32'd0);
      check("rst_cnt", 32'({pkt_cnt1, pkt_cnt2}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_din_ready", 32'(din_ready), 32'd1);
      @(posedge clk); #1 rst_n = 1;

      foreach (vecs[i]) begin
         step(vecs[i]);
         check($sformatf("din_ready[%0d]", i), 32'(din_ready), 32'(vecs[i].exp_rdy));
         check($sformatf("busy[%0d]", i), 32'(busy), 32'(vecs[i].exp_busy));
      end

      // Reset during a packet routed to out2.
      step('{8'h81, 1, 1, 0, 1, 1, 1, 0});
      step('{8'h82, 1, 1, 0, 1, 1, 1, 1});
      @(posedge clk);
      #1 din_valid = 0; sel = 0;
      #2 rst_n = 0;
      #1;
      check("mid_rst_out", 32'({out1_valid, out1_last, out1, out2_valid, out2_last, out2}), 32'd0);
      check("mid_rst_cnt", 32'({pkt_cnt1, pkt_cnt2}), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_din_ready", 32'(din_ready), 32'd1);
      #3 rst_n = 1;

      // First post-reset packet goes to out1; five packets exercise the counter wrap.
      for (int i = 0; i < 5; i++) begin
         step('{8'h9C + 8'(i), 1, 0, 1, 1, 1, 1, 0});
         step(idle);
         if (i == 0) check("post_rst_route", 32'({out1_valid, out1, out2_valid}), 32'({1'b1, 8'h9C, 1'b0}));
         step(idle);
         check($sformatf("wrap_cnt1[%0d]", i), 32'(pkt_cnt1), 32'(wrap_exp[i]));
      end
      step(idle);
      step(idle);
      check("q1_drained", 32'(q1.size()), 32'd0);
      check("q2_drained", 32'(q2.size()), 32'd0);
      check("final_cnt2", 32'(pkt_cnt2), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
